// File: rtl/tlp_xcvr_pkg.sv
// Shared TLP transceiver definitions: FPGA->CPU ring geometry and 3DW MWr header packing.
package tlp_xcvr_pkg;

   localparam int F2C_NUMCHUNKS = 4;
   localparam int F2C_CHUNKSIZE = 1024;
   localparam int F2C_TLPSIZE   = 128;

   typedef logic [$clog2(F2C_NUMCHUNKS)-1:0] F2CChunkIndex;

   localparam logic [1:0] FMT_3DW_DATA = 2'b10;
   localparam logic [4:0] TYPE_MEM     = 5'b00000;

   // Beat 0 of a 3DW memory write: {DW1, DW0}
   function automatic logic [63:0] pack_mwr_qw0(
      input logic [15:0] req_id,
      input logic [9:0]  length,
      input logic [3:0]  first_be,
      input logic [3:0]  last_be
   );
      return {req_id, 8'h00, last_be, first_be,
              1'b0, FMT_3DW_DATA, TYPE_MEM, 14'h0000, length};
   endfunction

endpackage

// File: rtl/f2c_hdr_gen.sv
// Combinational 3DW MWr header builder: produces the two header QWs of a TLP.
module f2c_hdr_gen
   import tlp_xcvr_pkg::*;
(
   input  logic [15:0] req_id,
   input  logic [31:0] addr,
   input  logic [9:0]  length,
   input  logic [3:0]  first_be,
   input  logic [3:0]  last_be,
   output logic [63:0] hdr_qw0,
   output logic [63:0] hdr_qw1
);

   always_comb begin
      hdr_qw0 = pack_mwr_qw0(req_id, length, first_be, last_be);
      hdr_qw1 = {32'h0000_0000, addr & 32'hFFFF_FFFC};
   end

endmodule

// File: rtl/f2c_dma_writer.sv
// FPGA->CPU DMA writer: streams application QWs into a host ring as MWr TLPs and
// posts the updated write pointer to the metrics buffer after every chunk.
module f2c_dma_writer #(
   parameter int F2C_NUMCHUNKS = tlp_xcvr_pkg::F2C_NUMCHUNKS,
   parameter int F2C_CHUNKSIZE = tlp_xcvr_pkg::F2C_CHUNKSIZE,
   parameter int F2C_TLPSIZE   = tlp_xcvr_pkg::F2C_TLPSIZE
) (
   input  logic                             clk_in,
   input  logic                             reset_in,
   input  logic [12:0]                      cfgBusDev_in,
   input  logic                             enable_in,
   input  logic [28:0]                      f2cBase_in,
   input  logic [28:0]                      mtrBase_in,
   input  logic [$clog2(F2C_NUMCHUNKS)-1:0] rdPtr_in,
   input  logic [63:0]                      f2cData_in,
   input  logic                             f2cValid_in,
   output logic                             f2cReady_out,
   output logic [63:0]                      txData_out,
   output logic                             txValid_out,
   input  logic                             txReady_in,
   output logic                             txSOP_out,
   output logic                             txEOP_out
);
   import tlp_xcvr_pkg::*;

   localparam int PTR_W          = $clog2(F2C_NUMCHUNKS);
   localparam int TLPS_PER_CHUNK = F2C_CHUNKSIZE / F2C_TLPSIZE;
   localparam int QWS_PER_TLP    = F2C_TLPSIZE / 8;
   localparam int TLP_W          = (TLPS_PER_CHUNK > 1) ? $clog2(TLPS_PER_CHUNK) : 1;
   localparam int QW_W           = (QWS_PER_TLP > 1) ? $clog2(QWS_PER_TLP) : 1;
   localparam logic [TLP_W-1:0] LAST_TLP = TLP_W'(TLPS_PER_CHUNK - 1);
   localparam logic [QW_W-1:0]  LAST_QW  = QW_W'(QWS_PER_TLP - 1);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, MHDR0, MHDR1, MDATA} state_t;

   state_t           state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] next_ptr;
   logic [TLP_W-1:0] tlp_idx;
   logic [QW_W-1:0]  qw_idx;
   logic             is_mtr;
   logic             xfer;
   logic [31:0]      data_addr;
   logic [63:0]      hdr_qw0;
   logic [63:0]      hdr_qw1;

   assign next_ptr  = wr_ptr + 1'b1;
   assign is_mtr    = (state == MHDR0) || (state == MHDR1) || (state == MDATA);
   assign xfer      = txValid_out & txReady_in;
   assign data_addr = {f2cBase_in, 3'b000}
                    + (32'(wr_ptr)  * 32'(F2C_CHUNKSIZE))
                    + (32'(tlp_idx) * 32'(F2C_TLPSIZE));

   f2c_hdr_gen u_hdr_gen (
      .req_id   ({cfgBusDev_in, 3'b000}),
      .addr     (is_mtr ? {mtrBase_in, 3'b000} : data_addr),
      .length   (is_mtr ? 10'd1 : 10'(F2C_TLPSIZE / 4)),
      .first_be (4'hF),
      .last_be  (is_mtr ? 4'h0 : 4'hF),
      .hdr_qw0  (hdr_qw0),
      .hdr_qw1  (hdr_qw1)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         tlp_idx <= '0;
         qw_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Ring-full and enable are only evaluated here, so a started chunk always completes
               if (!enable_in)
                  wr_ptr <= '0;
               else if (f2cValid_in && (next_ptr != rdPtr_in))
                  state <= HDR0;
            end
            HDR0:  if (xfer) state <= HDR1;
            HDR1: begin
               if (xfer) begin
                  qw_idx <= '0;
                  state  <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  if (qw_idx == LAST_QW) begin
                     qw_idx <= '0;
                     if (tlp_idx == LAST_TLP) begin
                        state <= MHDR0;
                     end else begin
                        tlp_idx <= tlp_idx + 1'b1;
                        state   <= HDR0;
                     end
                  end else begin
                     qw_idx <= qw_idx + 1'b1;
                  end
               end
            end
            MHDR0: if (xfer) state <= MHDR1;
            MHDR1: if (xfer) state <= MDATA;
            MDATA: begin
               if (xfer) begin
                  wr_ptr  <= next_ptr;
                  tlp_idx <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Beat outputs decode the registered state; only DATA passes the stream straight through
   always_comb begin
      txValid_out  = 1'b0;
      txSOP_out    = 1'b0;
      txEOP_out    = 1'b0;
      txData_out   = '0;
      f2cReady_out = 1'b0;
      case (state)
         HDR0, MHDR0: begin
            txValid_out = 1'b1;
            txSOP_out   = 1'b1;
            txData_out  = hdr_qw0;
         end
         HDR1, MHDR1: begin
            txValid_out = 1'b1;
            txData_out  = hdr_qw1;
         end
         DATA: begin
            txValid_out  = f2cValid_in;
            txEOP_out    = (qw_idx == LAST_QW);
            txData_out   = f2cData_in;
            f2cReady_out = txReady_in;
         end
         MDATA: begin
            txValid_out = 1'b1;
            txEOP_out   = 1'b1;
            txData_out  = {32'h0000_0000, 32'(next_ptr)};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_f2c_dma_writer.sv
// Directed bench for f2c_dma_writer: parses the TX beat stream and checks headers,
// addresses, payload continuity, ring-full, disable and reset behaviour.
module tb_f2c_dma_writer;
   import tlp_xcvr_pkg::*;

   localparam logic [63:0] DATA_QW0 = 64'h0040_00FF_4000_0020;
   localparam logic [63:0] MTR_QW0  = 64'h0040_000F_4000_0001;

   logic         clk_in;
   logic         reset_in;
   logic         enable_in;
   F2CChunkIndex rdPtr_in;
   logic [63:0]  f2cData_in;
   logic         f2cValid_in;
   logic         f2cReady_out;
   logic [63:0]  txData_out;
   logic         txValid_out;
   logic         txReady_in;
   logic         txSOP_out;
   logic         txEOP_out;

   int           checks;
   int           errors;
   int           cyc;
   logic         stall_mode;
   logic         fire;
   logic [63:0]  src;
   logic [63:0]  exp_pay;
   int           bpos;
   int           dchunk;
   logic         is_mtr;
   int           first_sop_cyc;
   int           en_cyc;
   int           base;
   logic [31:0]  data_addrs[$];
   logic [31:0]  mtr_vals[$];
   int           mtr_sop_cyc[$];

   f2c_dma_writer #(
      .F2C_NUMCHUNKS (4),
      .F2C_CHUNKSIZE (1024),
      .F2C_TLPSIZE   (128)
   ) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .cfgBusDev_in (13'h0008),
      .enable_in    (enable_in),
      .f2cBase_in   (29'h0),
      .mtrBase_in   (29'h200),
      .rdPtr_in     (rdPtr_in),
      .f2cData_in   (f2cData_in),
      .f2cValid_in  (f2cValid_in),
      .f2cReady_out (f2cReady_out),
      .txData_out   (txData_out),
      .txValid_out  (txValid_out),
      .txReady_in   (txReady_in),
      .txSOP_out    (txSOP_out),
      .txEOP_out    (txEOP_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc = cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Source and sink stimulus, applied just after each active edge
   always begin
      @(posedge clk_in);
      #1;
      if (fire) src = src + 1;
      f2cData_in  = src;
      f2cValid_in = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      txReady_in  = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Beat monitor: samples on the falling edge what the next rising edge will transfer
   always @(negedge clk_in) begin
      fire = f2cValid_in & f2cReady_out;
      if (!reset_in && txValid_out && txReady_in) begin
         if (bpos == 0) begin
            is_mtr = (dchunk == 8);
            check("sop_hdr0", 64'(txSOP_out), 64'd1);
            check("eop_hdr0", 64'(txEOP_out), 64'd0);
            check("hdr0", txData_out, is_mtr ? MTR_QW0 : DATA_QW0);
            if (is_mtr) mtr_sop_cyc.push_back(cyc);
            else if (first_sop_cyc < 0) first_sop_cyc = cyc;
            bpos = 1;
         end else if (bpos == 1) begin
            check("sop_hdr1", 64'(txSOP_out), 64'd0);
            check("eop_hdr1", 64'(txEOP_out), 64'd0);
            check("hdr1_hi", 64'(txData_out[63:32]), 64'd0);
            if (is_mtr) check("mtr_addr", 64'(txData_out[31:0]), 64'h1000);
            else data_addrs.push_back(txData_out[31:0]);
            bpos = 2;
         end else if (is_mtr) begin
            check("sop_mdata", 64'(txSOP_out), 64'd0);
            check("eop_mdata", 64'(txEOP_out), 64'd1);
            check("mdata_hi", 64'(txData_out[63:32]), 64'd0);
            mtr_vals.push_back(txData_out[31:0]);
            dchunk = 0;
            bpos   = 0;
         end else begin
            check("sop_data", 64'(txSOP_out), 64'd0);
            check("payload", txData_out, exp_pay);
            check("eop_data", 64'(txEOP_out), 64'(bpos == 17));
            exp_pay = exp_pay + 1;
            if (bpos == 17) begin
               bpos   = 0;
               dchunk = dchunk + 1;
            end else begin
               bpos = bpos + 1;
            end
         end
      end
   end

   task automatic wait_mtr(input int n);
      int k = 0;
      while (mtr_vals.size() < n && k < 20000) begin
         @(negedge clk_in);
         k++;
      end
      check("wait_mtr", 64'(mtr_vals.size()), 64'(n));
   endtask

   task automatic wait_addr(input int n);
      int k = 0;
      while (data_addrs.size() < n && k < 20000) begin
         @(negedge clk_in);
         k++;
      end
      check("wait_addr", 64'(data_addrs.size()), 64'(n));
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0; stall_mode = 1'b0; fire = 1'b0;
      src = '0; exp_pay = '0; bpos = 0; dchunk = 0; is_mtr = 1'b0;
      first_sop_cyc = -1; en_cyc = 0; base = 0;
      reset_in = 1'b1; enable_in = 1'b0; rdPtr_in = '0;
      f2cData_in = '0; f2cValid_in = 1'b0; txReady_in = 1'b1;

      // Reset state
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_valid", 64'(txValid_out), 64'd0);
      check("rst_sop", 64'(txSOP_out), 64'd0);
      check("rst_eop", 64'(txEOP_out), 64'd0);
      check("rst_ready", 64'(f2cReady_out), 64'd0);
      check("rst_data", txData_out, 64'd0);
      tick();
      reset_in = 1'b0;
      repeat (5) @(posedge clk_in);
      @(negedge clk_in);
      check("dis_valid", 64'(txValid_out), 64'd0);
      check("dis_ready", 64'(f2cReady_out), 64'd0);

      // Fill the ring with rdPtr held at 0: three chunks, then full
      tick();
      enable_in = 1'b1;
      en_cyc = cyc;
      wait_mtr(3);
      repeat (20) @(negedge clk_in);
      check("full_mtr_cnt", 64'(mtr_vals.size()), 64'd3);
      check("full_tlp_cnt", 64'(data_addrs.size()), 64'd24);
      check("full_ready", 64'(f2cReady_out), 64'd0);
      check("full_valid", 64'(txValid_out), 64'd0);
      check("mtr0", 64'(mtr_vals[0]), 64'd1);
      check("mtr1", 64'(mtr_vals[1]), 64'd2);
      check("mtr2", 64'(mtr_vals[2]), 64'd3);
      check("first_hdr_lat", 64'(first_sop_cyc - en_cyc), 64'd1);
      check("chunk_cycles", 64'(mtr_sop_cyc[0] - first_sop_cyc), 64'd144);
      check("chunk_period", 64'(mtr_sop_cyc[1] - mtr_sop_cyc[0]), 64'd148);
      for (int i = 0; i < 24; i++)
         check("addr_fill", 64'(data_addrs[i]), 64'(i * 128));

      // Host frees one slot: chunk 3 at 0xC00, pointer wraps to 0
      tick();
      rdPtr_in = 2'd1;
      wait_mtr(4);
      check("mtr3_wrap", 64'(mtr_vals[3]), 64'd0);
      check("addr_c00", 64'(data_addrs[24]), 64'h0C00);
      check("addr_f80", 64'(data_addrs[31]), 64'h0F80);

      // Random source and sink stalls
      tick();
      stall_mode = 1'b1;
      rdPtr_in = 2'd0;
      wait_mtr(7);
      tick();
      stall_mode = 1'b0;
      check("stall_mtr4", 64'(mtr_vals[4]), 64'd1);
      check("stall_mtr5", 64'(mtr_vals[5]), 64'd2);
      check("stall_mtr6", 64'(mtr_vals[6]), 64'd3);
      for (int i = 32; i < 56; i++)
         check("addr_stall", 64'(data_addrs[i]), 64'((i - 32) * 128));

      // Disable in the middle of chunk 0; it completes, then pointer is forced to 0
      tick();
      rdPtr_in = 2'd2;
      wait_addr(67);
      tick();
      enable_in = 1'b0;
      wait_mtr(9);
      repeat (20) @(negedge clk_in);
      check("dis_mtr7", 64'(mtr_vals[7]), 64'd0);
      check("dis_mtr8", 64'(mtr_vals[8]), 64'd1);
      check("dis_tlp_cnt", 64'(data_addrs.size()), 64'd72);
      check("dis_idle_valid", 64'(txValid_out), 64'd0);
      check("dis_idle_ready", 64'(f2cReady_out), 64'd0);
      check("addr_chunk3", 64'(data_addrs[56]), 64'h0C00);
      check("addr_chunk0", 64'(data_addrs[64]), 64'h0000);
      tick();
      enable_in = 1'b1;
      wait_addr(73);
      check("reen_addr", 64'(data_addrs[72]), 64'h0000);

      // Reset in the middle of a payload
      begin
         int k = 0;
         while (bpos < 4 && k < 1000) begin
            @(negedge clk_in);
            k++;
         end
         check("wait_data", 64'(bpos >= 4), 64'd1);
      end
      tick();
      reset_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check("mid_rst_valid", 64'(txValid_out), 64'd0);
      check("mid_rst_sop", 64'(txSOP_out), 64'd0);
      check("mid_rst_eop", 64'(txEOP_out), 64'd0);
      check("mid_rst_ready", 64'(f2cReady_out), 64'd0);
      @(negedge clk_in);
      bpos = 0;
      dchunk = 0;
      exp_pay = src;
      base = data_addrs.size();
      tick();
      reset_in = 1'b0;
      wait_addr(base + 2);
      check("post_rst_addr0", 64'(data_addrs[base]), 64'h0000);
      check("post_rst_addr1", 64'(data_addrs[base + 1]), 64'h0080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
